// File: rtl/ray_gen_scheduler.sv
// Per-frame camera-ray generator and single-outstanding-ray dispatcher to the ray marcher.
// Define RAYGEN_NORMALIZE_EN to normalise ray directions with Newton-Raphson inverse sqrt.
package vector_pkg;
    typedef logic signed [31:0] fp;
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    // Q8.24 multiply: signed 64-bit product, arithmetic shift right 24, truncate.
    function automatic fp fmul(input fp a, input fp b);
        return 32'((64'(a) * 64'(b)) >>> 24);
    endfunction
endpackage

module ray_gen_scheduler
    import vector_pkg::*;
#(
    parameter int unsigned IMG_W    = 320,
    parameter int unsigned IMG_H    = 240,
    parameter logic [31:0] PIX_STEP = 32'h00022222,
    parameter logic [31:0] FOCAL    = 32'h01000000,
    parameter int unsigned NR_ITERS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  vec3                        cam_origin,
    output logic                       march_valid_in,
    output vec3                        ray_origin,
    output vec3                        ray_dir,
    input  logic                       march_valid_out,
    input  logic                       march_hit,
    input  vec3                        march_point,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [$clog2(IMG_W)-1:0]   pix_x,
    output logic [$clog2(IMG_H)-1:0]   pix_y,
    output logic                       pix_hit,
    output vec3                        pix_point,
    output logic                       pix_last,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam fp F_FP = $signed(FOCAL);

    if (NR_ITERS < 1 || NR_ITERS > 8) begin : g_bad_iters
        $error("NR_ITERS must be in 1..8");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_NORM, S_ISSUE, S_WAIT, S_EMIT, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [XW-1:0]   r_x, w_x, r_pix_x, w_pix_x;
    logic [YW-1:0]   r_y, w_y, r_pix_y, w_pix_y;
    vec3             r_ray_origin, w_ray_origin;
    vec3             r_ray_dir, w_ray_dir;
    vec3             r_pix_point, w_pix_point;
    logic            r_march_valid_in, w_march_valid_in;
    logic            r_pix_valid, w_pix_valid;
    logic            r_pix_hit, w_pix_hit;
    logic            r_pix_last, w_pix_last;
    logic            r_busy, w_busy;
    logic            r_frame_done, w_frame_done;
    logic            w_is_last;
    fp               w_xoff, w_yoff, w_pix_u, w_pix_v;

`ifdef RAYGEN_NORMALIZE_EN
    localparam int unsigned IT_W = 4;
    localparam fp TWO        = 32'sh02000000;
    localparam fp ONE        = 32'sh01000000;
    localparam fp SEED_LO    = 32'sh00A00000;
    localparam fp HALF       = 32'sh00800000;
    localparam fp THREE_HALF = 32'sh01800000;

    fp               r_u, w_u, r_v, w_v, r_s, w_s, r_r, w_r;
    logic [IT_W-1:0] r_iter, w_iter;
    fp               w_s_calc, w_r2, w_sr2, w_t, w_r_nr;

    // One Newton-Raphson inverse-sqrt step per NORM cycle.
    always_comb begin
        w_s_calc = fmul(w_pix_u, w_pix_u) + fmul(w_pix_v, w_pix_v) + fmul(F_FP, F_FP);
        w_r2     = fmul(r_r, r_r);
        w_sr2    = fmul(r_s, w_r2);
        w_t      = THREE_HALF - fmul(HALF, w_sr2);
        w_r_nr   = fmul(r_r, w_t);
    end
`endif

    // Screen-space offsets of the current pixel, integer offset times Q8.24 step.
    always_comb begin
        w_xoff    = $signed(32'(r_x)) - $signed(32'(IMG_W / 2));
        w_yoff    = $signed(32'(IMG_H / 2)) - $signed(32'(r_y));
        w_pix_u   = 32'(64'(w_xoff) * 64'($signed(PIX_STEP)));
        w_pix_v   = 32'(64'(w_yoff) * 64'($signed(PIX_STEP)));
        w_is_last = (r_x == XW'(IMG_W - 1)) && (r_y == YW'(IMG_H - 1));
    end

    always_comb begin
        w_next       = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_ray_origin = r_ray_origin;
        w_ray_dir    = r_ray_dir;
        w_pix_x      = r_pix_x;
        w_pix_y      = r_pix_y;
        w_pix_hit    = r_pix_hit;
        w_pix_point  = r_pix_point;
        w_pix_last   = r_pix_last;
`ifdef RAYGEN_NORMALIZE_EN
        w_u          = r_u;
        w_v          = r_v;
        w_s          = r_s;
        w_r          = r_r;
        w_iter       = r_iter;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ray_origin = cam_origin;
                    w_x          = '0;
                    w_y          = '0;
                    w_next       = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef RAYGEN_NORMALIZE_EN
                w_u    = w_pix_u;
                w_v    = w_pix_v;
                w_s    = w_s_calc;
                w_r    = (w_s_calc < TWO) ? ONE : SEED_LO;
                w_iter = '0;
                w_next = S_NORM;
`else
                w_ray_dir = '{x: w_pix_u, y: w_pix_v, z: F_FP};
                w_next    = S_ISSUE;
`endif
            end
`ifdef RAYGEN_NORMALIZE_EN
            S_NORM: begin
                w_r    = w_r_nr;
                w_iter = r_iter + IT_W'(1);
                if (r_iter == IT_W'(NR_ITERS - 1)) begin
                    w_ray_dir = '{x: fmul(r_u, w_r_nr), y: fmul(r_v, w_r_nr), z: fmul(F_FP, w_r_nr)};
                    w_next    = S_ISSUE;
                end
            end
`endif
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (march_valid_out) begin
                    w_pix_hit   = march_hit;
                    w_pix_point = march_point;
                    w_pix_x     = r_x;
                    w_pix_y     = r_y;
                    w_pix_last  = w_is_last;
                    w_next      = S_EMIT;
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    if (w_is_last) begin
                        w_next = S_DONE;
                    end else begin
                        if (r_x == XW'(IMG_W - 1)) begin
                            w_x = '0;
                            w_y = r_y + YW'(1);
                        end else begin
                            w_x = r_x + XW'(1);
                        end
                        w_next = S_SETUP;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Status outputs are registered copies of the next state.
        w_march_valid_in = (w_next == S_ISSUE);
        w_pix_valid      = (w_next == S_EMIT);
        w_busy           = (w_next != S_IDLE);
        w_frame_done     = (w_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_x              <= '0;
            r_y              <= '0;
            r_ray_origin     <= '0;
            r_ray_dir        <= '0;
            r_pix_x          <= '0;
            r_pix_y          <= '0;
            r_pix_hit        <= 1'b0;
            r_pix_point      <= '0;
            r_pix_last       <= 1'b0;
            r_march_valid_in <= 1'b0;
            r_pix_valid      <= 1'b0;
            r_busy           <= 1'b0;
            r_frame_done     <= 1'b0;
`ifdef RAYGEN_NORMALIZE_EN
            r_u              <= '0;
            r_v              <= '0;
            r_s              <= '0;
            r_r              <= '0;
            r_iter           <= '0;
`endif
        end else begin
            r_state          <= w_next;
            r_x              <= w_x;
            r_y              <= w_y;
            r_ray_origin     <= w_ray_origin;
            r_ray_dir        <= w_ray_dir;
            r_pix_x          <= w_pix_x;
            r_pix_y          <= w_pix_y;
            r_pix_hit        <= w_pix_hit;
            r_pix_point      <= w_pix_point;
            r_pix_last       <= w_pix_last;
            r_march_valid_in <= w_march_valid_in;
            r_pix_valid      <= w_pix_valid;
            r_busy           <= w_busy;
            r_frame_done     <= w_frame_done;
`ifdef RAYGEN_NORMALIZE_EN
            r_u              <= w_u;
            r_v              <= w_v;
            r_s              <= w_s;
            r_r              <= w_r;
            r_iter           <= w_iter;
`endif
        end
    end

    assign march_valid_in = r_march_valid_in;
    assign ray_origin     = r_ray_origin;
    assign ray_dir        = r_ray_dir;
    assign pix_valid      = r_pix_valid;
    assign pix_x          = r_pix_x;
    assign pix_y          = r_pix_y;
    assign pix_hit        = r_pix_hit;
    assign pix_point      = r_pix_point;
    assign pix_last       = r_pix_last;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;
endmodule

// File: tb/tb_ray_gen_scheduler.sv
// Scoreboard bench for ray_gen_scheduler on a 4x4 image with a 3-cycle stub marcher.
module tb_ray_gen_scheduler;
    import vector_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;
`ifdef RAYGEN_NORMALIZE_EN
    localparam int TOL = 16;
    localparam int LAT = 6;
    localparam logic [31:0] D0X = 32'hFF6C32C6;
    localparam logic [31:0] D0Y = 32'h0093CD3A;
    localparam logic [31:0] D0Z = 32'h0093CD3A;
`else
    localparam int TOL = 0;
    localparam int LAT = 2;
    localparam logic [31:0] D0X = 32'hFF000000;
    localparam logic [31:0] D0Y = 32'h01000000;
    localparam logic [31:0] D0Z = 32'h01000000;
`endif

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic       hit;
        vec3        point;
        logic       last;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    vec3  cam_origin = '0;
    logic march_valid_in, march_valid_out = 1'b0, march_hit = 1'b0;
    vec3  ray_origin, ray_dir, march_point = '0, pix_point;
    logic pix_valid, pix_ready = 1'b1, pix_hit, pix_last, busy, frame_done;
    logic [1:0] pix_x, pix_y;

    int   n_checks = 0, n_pass = 0;
    int   cyc = 0, start_cyc = 0, stub_idx = 0, acc_cnt = 0, last_acc_cyc = 0;
    bit   stub_en = 1'b1, ovr_en = 1'b0;
    vec3  exp_origin = '0;
    pix_t exp_q[$];

    ray_gen_scheduler #(
        .IMG_W(W), .IMG_H(H), .PIX_STEP(32'h00800000), .FOCAL(32'h01000000), .NR_ITERS(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cam_origin(cam_origin),
        .march_valid_in(march_valid_in), .ray_origin(ray_origin), .ray_dir(ray_dir),
        .march_valid_out(march_valid_out), .march_hit(march_hit), .march_point(march_point),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_hit(pix_hit), .pix_point(pix_point), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_tol(input string name, input fp act, input fp exp, input int tol);
        int d;
        n_checks++;
        d = int'(act) - int'(exp);
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %h expected %h +/-%0d", name, act, exp, tol);
    endtask

    // Stub marcher: replies 3 cycles after each issue and records the expected pixel.
    initial begin
        int idx;
        vec3 cap_dir, cap_org;
        pix_t e;
        forever begin
            @(posedge clk); #1;
            if (march_valid_in) begin
                idx = stub_idx;
                stub_idx++;
                cap_dir = ray_dir;
                cap_org = ray_origin;
                chk("ray_origin", 320'(ray_origin), 320'(exp_origin));
                if (idx == 0) begin
                    chk("first_issue_latency", 320'(cyc - start_cyc), 320'(LAT));
                    chk_tol("dir00_x", ray_dir.x, $signed(D0X), TOL);
                    chk_tol("dir00_y", ray_dir.y, $signed(D0Y), TOL);
                    chk_tol("dir00_z", ray_dir.z, $signed(D0Z), TOL);
                end
                if (idx == 10) begin
                    chk_tol("dir22_x", ray_dir.x, 32'sh0, TOL);
                    chk_tol("dir22_y", ray_dir.y, 32'sh0, TOL);
                    chk_tol("dir22_z", ray_dir.z, 32'sh01000000, TOL);
                end
                repeat (3) @(posedge clk);
                #1;
                if (stub_en) begin
                    chk("wait_hold", 320'({ray_dir, ray_origin}), 320'({cap_dir, cap_org}));
                    e.x    = 2'(idx % 4);
                    e.y    = 2'(idx / 4);
                    e.last = (idx == 15);
                    if (ovr_en) begin
                        e.hit   = 1'b1;
                        e.point = '{x: 32'sh0, y: 32'sh0, z: 32'sh01000000};
                        ovr_en  = 1'b0;
                    end else begin
                        e.hit   = idx[0];
                        e.point = '{x: 32'(idx), y: 32'(idx * 3 + 1), z: 32'shFF000000};
                    end
                    march_hit       = e.hit;
                    march_point     = e.point;
                    march_valid_out = 1'b1;
                    exp_q.push_back(e);
                    @(posedge clk); #1;
                    march_valid_out = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted pixel is compared with the oldest expectation.
    initial begin
        pix_t a, e;
        forever begin
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                a.x = pix_x; a.y = pix_y; a.hit = pix_hit; a.point = pix_point; a.last = pix_last;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pix", 320'(a), 320'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_beat", 320'(a), 320'(e));
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input vec3 org);
        @(posedge clk); #1;
        stub_idx   = 0;
        acc_cnt    = 0;
        start_cyc  = cyc;
        cam_origin = org;
        exp_origin = org;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        cam_origin = '{x: 32'sh7, y: 32'sh7, z: 32'sh7};
        chk("busy_after_start", 320'(busy), 320'(1));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!frame_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            chk({name, "_done_timeout"}, 320'(0), 320'(1));
        end else begin
            chk({name, "_done_timing"}, 320'(cyc), 320'(last_acc_cyc + 1));
            chk({name, "_beats"}, 320'(acc_cnt), 320'(16));
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk({name, "_done_pulse_busy"}, 320'({frame_done, busy}), 320'(0));
            repeat (4) @(negedge clk);
            chk({name, "_start_in_done_ignored"}, 320'({busy, march_valid_in}), 320'(0));
        end
    endtask

    function automatic logic [319:0] all_out();
        return 320'({march_valid_in, ray_origin, ray_dir, pix_valid, pix_x, pix_y,
                     pix_hit, pix_point, pix_last, busy, frame_done});
    endfunction

    initial begin
        logic [319:0] snap;
        int n;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 320'(0));
        rst = 1'b1;

        // Frame 1: free-running, with an ignored start pulse mid-frame.
        start_frame('{x: 32'sh0, y: 32'sh0, z: 32'shFE000000});
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("f1");

        // Frame 2: first pixel stalled by pix_ready=0.
        pix_ready = 1'b0;
        ovr_en    = 1'b1;
        start_frame('{x: 32'sh01000000, y: 32'shFF800000, z: 32'shFD000000});
        n = 0;
        while (!pix_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_pix_valid_seen", 320'(pix_valid), 320'(1));
        snap = 320'({pix_valid, pix_x, pix_y, pix_hit, pix_point, pix_last});
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_stable", 320'({pix_valid, pix_x, pix_y, pix_hit, pix_point, pix_last}), snap);
            chk("stall_no_issue", 320'(march_valid_in), 320'(0));
        end
        pix_ready = 1'b1;
        wait_done("f2");

        // Frame 3: reset while pixel 5 waits on the marcher, then a stale reply.
        start_frame('{x: 32'sh0, y: 32'sh0, z: 32'shFE000000});
        n = 0;
        while (stub_idx < 6 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reached_pixel5", 320'(stub_idx), 320'(6));
        stub_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        march_hit       = 1'b1;
        march_point     = '{x: 32'sh5, y: 32'sh5, z: 32'sh5};
        march_valid_out = 1'b1;
        @(posedge clk); #1 march_valid_out = 1'b0;
        chk("midframe_reset_outputs", all_out(), 320'(0));
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pix_valid) seen = 1'b1;
        end
        chk("no_pix_after_reset", 320'(seen), 320'(0));
        chk("queue_empty_after_reset", 320'(exp_q.size()), 320'(0));
        stub_en = 1'b1;

        // Frame 4: restart after reset begins again at pixel (0,0).
        start_frame('{x: 32'sh01000000, y: 32'sh02000000, z: 32'shFD000000});
        wait_done("f4");
        chk("queue_empty_end", 320'(exp_q.size()), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
